elevator_ctrl: RTL
==================

// Module: elevator_ctrl
// PURPOSE
//  Elevator car controller; the stage directly upstream of the floor display block.
//  - Latches one-cycle floor-call pulses.
//  - Serves calls in SCAN order, moving one floor per MOVE_TICKS clocks.
//  - Holds the door open for DOOR_TICKS clocks at each served floor.
//  - Publishes cur_floor, direction and door state; the floor display block turns these into RGB LED colours.
// PARAMETERS
//  N_FLOORS    4    number of floors, 2..16; floor 0 is the bottom floor
//  FLOOR_W     2    width of cur_floor; must equal $clog2(N_FLOORS)
//  MOVE_TICKS  50   clocks to travel one floor (>=2)
//  DOOR_TICKS  30   clocks the door stays open (>=2)
//  CNT_W       8    tick counter width; must hold max(MOVE_TICKS,DOOR_TICKS)-1
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         asynchronous, active-high reset
//  req_pulse    in   N_FLOORS  call pulses; bit i = floor i; may be multi-hot
//  cur_floor    out  FLOOR_W   floor the car is at or last passed
//  moving       out  1         1 in MOVE_UP / MOVE_DN
//  dir_up       out  1         last/current travel direction, 1 = up
//  door_open    out  1         1 in DOOR
//  arrive       out  1         1-cycle pulse on entering DOOR
//  req_pending  out  N_FLOORS  latched, unserved calls
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE, cur_floor=0, pending=0, timer=0.
//   - dir_up=1; all other outputs 0.
//   - A reset mid-move or mid-door drops the car to floor 0 and discards all calls.
//  Call latch: pending <= (pending | req_pulse) & ~clr each cycle.
//   - clr = the bit being served this cycle.
//   - In DOOR, a call for cur_floor is not latched; it reloads the door timer.
//   - A new call for a floor being cleared in the same cycle (non-DOOR) is kept.
//  Decisions are made from the registered pending vector only.
//   - A call at cycle t is visible at t+1.
//   - The earliest state change (moving=1 or door_open=1) is at t+2.
//  FSM states: IDLE, MOVE_UP, MOVE_DN, DOOR.
//   - above = |pending[N-1:cur+1]; below = |pending[cur-1:0].
//   IDLE:
//   - pending[cur] -> DOOR (clear bit, arrive=1).
//   - else above & (dir_up | ~below) -> MOVE_UP, dir_up=1.
//   - else below -> MOVE_DN, dir_up=0.
//   - else stay in IDLE.
//   MOVE_x: timer counts 0..MOVE_TICKS-1; on the terminal count:
//   - cur_floor +/-1 and timer=0.
//   - If pending[new] -> DOOR (clear bit, arrive=1).
//   - Else if calls remain further in the same direction -> keep moving.
//   - Else -> IDLE.
//   DOOR: timer counts 0..DOOR_TICKS-1, then -> IDLE, door_open=0 the next cycle.
//  Boundaries:
//   - cur_floor never leaves 0..N_FLOORS-1. MOVE_UP is never entered at the top floor; MOVE_DN is never entered at floor 0.
//   - Calls arriving mid-travel for floors already passed wait for the direction reversal.
//   - The timer is 0 on every state entry. The counter saturates and never wraps.
//  Outputs are all registered; no combinational path from input to output.
// STRUCTURE
//  - elevator_pkg: state localparams (IDLE=0, MOVE_UP=1, MOVE_DN=2, DOOR=3) and ST_W=2, shared with the floor display block.
//  - One sub-module, tick_timer (CNT_W): inputs clr, en, limit; output done.
//   - done = 1 when count == limit-1.
//   - Instantiated once and shared between MOVE and DOOR.
//  - Above/below masks are generated with a for-loop over N_FLOORS.
// TESTING  (N_FLOORS=4, MOVE_TICKS=4, DOOR_TICKS=3)
//  1. Reset released, no calls for 20 cycles -> cur_floor=0, moving=0, door_open=0, req_pending=0, dir_up=1.
//  2. Idle at floor 0, req_pulse=4'b0100 at t:
//     - moving=1 at t+2.
//     - cur_floor=1 at t+6, cur_floor=2 at t+10 with arrive=1.
//     - door_open=1 for 3 cycles, then IDLE.
//  3. Idle at floor 0, req_pulse=4'b0001 -> door_open=1 at t+2 and arrive=1; cur_floor stays 0; moving never 1.
//  4. Moving up from floor 0 toward 3 (pending=4'b1000); req_pulse=4'b0010 while cur_floor=2:
//     - The car serves floor 3 first, then goes MOVE_DN and opens at floor 1.
//     - req_pending ends at 0.
//  5. Door open at floor 2, req_pulse=4'b0100 on the 2nd door cycle -> door_open lasts 2+3 cycles; req_pending[2] stays 0.
//  6. rst pulsed while moving between floors 1 and 2 with pending=4'b1100 -> same cycle: cur_floor=0, moving=0, req_pending=0; idle thereafter.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared state encoding for the elevator car controller and the floor display block.
package elevator_pkg;

   localparam int ST_W = 2;

   localparam logic [ST_W-1:0] IDLE    = 2'd0;
   localparam logic [ST_W-1:0] MOVE_UP = 2'd1;
   localparam logic [ST_W-1:0] MOVE_DN = 2'd2;
   localparam logic [ST_W-1:0] DOOR    = 2'd3;

   typedef enum logic [ST_W-1:0] {
      S_IDLE    = IDLE,
      S_MOVE_UP = MOVE_UP,
      S_MOVE_DN = MOVE_DN,
      S_DOOR    = DOOR
   } state_t;

endpackage

// File: rtl/elevator_tick_timer.sv
// Saturating tick counter shared by travel and door dwell timing.
module tick_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             done_o
);

   logic [CNT_W-1:0] count_q;

   assign done_o = (count_q == (limit_i - CNT_W'(1)));

   // Count up while enabled, stop at the terminal count instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i && !done_o) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator car controller: latches floor calls and serves them in SCAN order.
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int N_FLOORS   = 4,
   parameter int FLOOR_W    = 2,
   parameter int MOVE_TICKS = 50,
   parameter int DOOR_TICKS = 30,
   parameter int CNT_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_FLOORS-1:0] req_pulse_i,
   output logic [FLOOR_W-1:0]  cur_floor_o,
   output logic                moving_o,
   output logic                dir_up_o,
   output logic                door_open_o,
   output logic                arrive_o,
   output logic [N_FLOORS-1:0] req_pending_o
);

   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

   state_t               state_q, state_d;
   logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
   logic [N_FLOORS-1:0]  pending_q, pending_d;
   logic                 dir_up_q, dir_up_d;
   logic                 arrive_q, arrive_d;

   logic [N_FLOORS-1:0]  clrMask;
   logic [N_FLOORS-1:0]  doorMask;
   logic [FLOOR_W-1:0]   nextFloor;
   logic                 aboveCur;
   logic                 belowCur;
   logic                 timerClr;
   logic                 timerEn;
   logic                 timerDone;
   logic [CNT_W-1:0]     timerLimit;

   function automatic logic [N_FLOORS-1:0] floorBit(input logic [FLOOR_W-1:0] f);
      return {{(N_FLOORS-1){1'b0}}, 1'b1} << f;
   endfunction

   function automatic logic callsAbove(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]  f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (i > int'(f)) r = r | p[i];
      end
      return r;
   endfunction

   function automatic logic callsBelow(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]  f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (i < int'(f)) r = r | p[i];
      end
      return r;
   endfunction

   assign aboveCur   = callsAbove(pending_q, cur_floor_q);
   assign belowCur   = callsBelow(pending_q, cur_floor_q);
   assign timerEn    = (state_q != S_IDLE);
   assign timerLimit = (state_q == S_DOOR) ? CNT_W'(DOOR_TICKS) : CNT_W'(MOVE_TICKS);
   assign doorMask   = (state_q == S_DOOR) ? floorBit(cur_floor_q) : '0;

   // Served floor is cleared, but a fresh call for it survives; door-floor calls only hold the door.
   assign pending_d = (pending_q & ~clrMask) | (req_pulse_i & ~doorMask);

   tick_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (timerClr),
      .en_i   (timerEn),
      .limit_i(timerLimit),
      .done_o (timerDone)
   );

   // Next-state decision from the registered call vector; timer restarts on every state entry or floor step.
   always_comb begin
      state_d     = state_q;
      cur_floor_d = cur_floor_q;
      dir_up_d    = dir_up_q;
      arrive_d    = 1'b0;
      timerClr    = 1'b0;
      clrMask     = '0;
      nextFloor   = cur_floor_q;
      case (state_q)
         S_IDLE: begin
            if (pending_q[cur_floor_q]) begin
               state_d  = S_DOOR;
               clrMask  = floorBit(cur_floor_q);
               arrive_d = 1'b1;
               timerClr = 1'b1;
            end else if (aboveCur && (dir_up_q || !belowCur)) begin
               state_d  = S_MOVE_UP;
               dir_up_d = 1'b1;
               timerClr = 1'b1;
            end else if (belowCur) begin
               state_d  = S_MOVE_DN;
               dir_up_d = 1'b0;
               timerClr = 1'b1;
            end
         end
         S_MOVE_UP: begin
            if (timerDone) begin
               timerClr = 1'b1;
               if (cur_floor_q == TOP_FLOOR) begin
                  state_d = S_IDLE;
               end else begin
                  nextFloor   = cur_floor_q + FLOOR_W'(1);
                  cur_floor_d = nextFloor;
                  if (pending_q[nextFloor]) begin
                     state_d  = S_DOOR;
                     clrMask  = floorBit(nextFloor);
                     arrive_d = 1'b1;
                  end else if (!callsAbove(pending_q, nextFloor)) begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         S_MOVE_DN: begin
            if (timerDone) begin
               timerClr = 1'b1;
               if (cur_floor_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  nextFloor   = cur_floor_q - FLOOR_W'(1);
                  cur_floor_d = nextFloor;
                  if (pending_q[nextFloor]) begin
                     state_d  = S_DOOR;
                     clrMask  = floorBit(nextFloor);
                     arrive_d = 1'b1;
                  end else if (!callsBelow(pending_q, nextFloor)) begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: begin
            if (req_pulse_i[cur_floor_q]) begin
               timerClr = 1'b1;
            end else if (timerDone) begin
               state_d  = S_IDLE;
               timerClr = 1'b1;
            end
         end
      endcase
   end

   // Car state registers; reset parks the car at floor 0 with all calls dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_floor_q <= '0;
         pending_q   <= '0;
         dir_up_q    <= 1'b1;
         arrive_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_floor_q <= cur_floor_d;
         pending_q   <= pending_d;
         dir_up_q    <= dir_up_d;
         arrive_q    <= arrive_d;
      end
   end

   assign cur_floor_o   = cur_floor_q;
   assign moving_o      = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DN);
   assign dir_up_o      = dir_up_q;
   assign door_open_o   = (state_q == S_DOOR);
   assign arrive_o      = arrive_q;
   assign req_pending_o = pending_q;

endmodule
